// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the TSC 16-bit CPU: steps the shared datapath
// through IF/ID/EX/MEM/WB, owns the memory handshake, write strobes and retire count.
module mc_control_fsm #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic [5:0]       func_code,
   input  logic             bcond,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_rw,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op_sel,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             pc_to_reg,
   output logic             wwd_valid,
   output logic             is_halt,
   output logic [CNT_W-1:0] num_inst
);

   localparam logic [3:0] OP_BNE = 4'd0;
   localparam logic [3:0] OP_BEQ = 4'd1;
   localparam logic [3:0] OP_BGZ = 4'd2;
   localparam logic [3:0] OP_BLZ = 4'd3;
   localparam logic [3:0] OP_ADI = 4'd4;
   localparam logic [3:0] OP_ORI = 4'd5;
   localparam logic [3:0] OP_LHI = 4'd6;
   localparam logic [3:0] OP_LWD = 4'd7;
   localparam logic [3:0] OP_SWD = 4'd8;
   localparam logic [3:0] OP_JMP = 4'd9;
   localparam logic [3:0] OP_JAL = 4'd10;
   localparam logic [3:0] OP_ALU = 4'd15;

   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_num_inst;

   logic w_rtype, w_alu_fn, w_jpr, w_jrl, w_wwd, w_hlt;
   logic w_jmp, w_jal, w_imm, w_mem, w_lwd, w_swd, w_branch, w_undef;
   logic w_id_done, w_retire;
   logic w_unused_bcond;

   // bcond is consumed by the datapath's conditional PC load, not by sequencing
   assign w_unused_bcond = bcond;

   assign w_rtype   = (opcode == OP_ALU);
   assign w_alu_fn  = (func_code <= 6'd7);
   assign w_jpr     = w_rtype && (func_code == FN_JPR);
   assign w_jrl     = w_rtype && (func_code == FN_JRL);
   assign w_wwd     = w_rtype && (func_code == FN_WWD);
   assign w_hlt     = w_rtype && (func_code == FN_HLT);
   assign w_jmp     = (opcode == OP_JMP);
   assign w_jal     = (opcode == OP_JAL);
   assign w_imm     = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
   assign w_lwd     = (opcode == OP_LWD);
   assign w_swd     = (opcode == OP_SWD);
   assign w_mem     = w_lwd || w_swd;
   assign w_branch  = (opcode == OP_BNE) || (opcode == OP_BEQ) ||
                      (opcode == OP_BGZ) || (opcode == OP_BLZ);
   assign w_undef   = ((opcode >= 4'd11) && (opcode <= 4'd14)) ||
                      (w_rtype && !w_alu_fn && !w_jpr && !w_jrl && !w_wwd && !w_hlt);
   assign w_id_done = w_jmp || w_jal || w_jpr || w_jrl || w_wwd || w_hlt || w_undef;

   // Retire is taken on the edge that leaves an instruction's final state
   assign w_retire = ((r_state == S_ID)  && w_id_done) ||
                     ((r_state == S_EX)  && w_branch)  ||
                     ((r_state == S_MEM) && w_swd && mem_ack) ||
                     (r_state == S_WB);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IF;
         r_num_inst <= '0;
      end else begin
         if (w_retire)
            r_num_inst <= r_num_inst + CNT_W'(1);
         case (r_state)
            S_IF: begin
               if (mem_ack)
                  r_state <= S_ID;
            end
            S_ID: begin
               if (w_hlt)
                  r_state <= S_HALT;
               else if (w_id_done)
                  r_state <= S_IF;
               else
                  r_state <= S_EX;
            end
            S_EX: begin
               if (w_rtype || w_imm)
                  r_state <= S_WB;
               else if (w_mem)
                  r_state <= S_MEM;
               else
                  r_state <= S_IF;
            end
            S_MEM: begin
               if (mem_ack)
                  r_state <= w_swd ? S_IF : S_WB;
            end
            S_WB:    r_state <= S_IF;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IF;
         endcase
      end
   end

   assign num_inst = r_num_inst;

   // Reset also forces the outputs low so mem_req drops without waiting for an edge
   always_comb begin
      mem_req       = 1'b0;
      mem_rw        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op_sel    = 2'b00;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      pc_to_reg     = 1'b0;
      wwd_valid     = 1'b0;
      is_halt       = 1'b0;
      if (!reset) begin
         case (r_state)
            S_IF: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ack;
               pc_write  = mem_ack;
            end
            S_ID: begin
               alu_src_b = 2'b11;
               if (w_jmp || w_jal) begin
                  pc_write  = 1'b1;
                  pc_source = 2'b10;
               end
               if (w_jpr || w_jrl) begin
                  pc_write  = 1'b1;
                  pc_source = 2'b11;
               end
               if (w_jal || w_jrl) begin
                  reg_write = 1'b1;
                  pc_to_reg = 1'b1;
               end
               wwd_valid = w_wwd;
            end
            S_EX: begin
               alu_src_a = 1'b1;
               if (w_rtype || w_imm) begin
                  alu_op_sel = 2'b10;
                  alu_src_b  = w_rtype ? 2'b00 : 2'b10;
               end else if (w_mem) begin
                  alu_src_b = 2'b10;
               end else if (w_branch) begin
                  alu_op_sel    = 2'b01;
                  pc_write_cond = 1'b1;
                  pc_source     = 2'b01;
               end
            end
            S_MEM: begin
               mem_req   = 1'b1;
               i_or_d    = 1'b1;
               mem_rw    = w_swd;
               mdr_write = w_lwd && mem_ack;
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = w_lwd;
            end
            S_HALT:  is_halt = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction expectation records are
// queued when an instruction is driven and compared when the DUT retires it.
module tb_mc_control_fsm;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       opcode;
   logic [5:0]       func_code;
   logic             bcond;
   logic             mem_ack;
   logic             mem_req, mem_rw, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond;
   logic [1:0]       pc_source, alu_src_b, alu_op_sel;
   logic             alu_src_a, reg_write, mem_to_reg, pc_to_reg, wwd_valid, is_halt;
   logic [CNT_W-1:0] num_inst;

   mc_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
      .bcond(bcond), .mem_ack(mem_ack), .mem_req(mem_req), .mem_rw(mem_rw),
      .i_or_d(i_or_d), .ir_write(ir_write), .mdr_write(mdr_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
      .wwd_valid(wwd_valid), .is_halt(is_halt), .num_inst(num_inst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [5:0] fn;
      logic       bc;
      int         wi;     // IF wait cycles before ack
      int         wm;     // MEM wait cycles before ack
      logic       noise;  // drive mem_ack high while no request is pending
      int         cyc;
      int         regw;
      int         mdr;
      int         pcw;
      int         pcwc;
      int         wwd;
      int         memw;
      int         p2r;
      int         m2r;
      int         src;    // pc_source in the instruction's last cycle
   } vec_t;

   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   mdl_cnt  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int op, input int fn, input int bc, input int wi,
                               input int wm, input int noise, input int cyc, input int regw,
                               input int mdr, input int pcw, input int pcwc, input int wwd,
                               input int memw, input int p2r, input int m2r, input int src);
      vec_t v;
      v.op = 4'(op); v.fn = 6'(fn); v.bc = 1'(bc); v.wi = wi; v.wm = wm; v.noise = 1'(noise);
      v.cyc = cyc; v.regw = regw; v.mdr = mdr; v.pcw = pcw; v.pcwc = pcwc; v.wwd = wwd;
      v.memw = memw; v.p2r = p2r; v.m2r = m2r; v.src = src;
      return v;
   endfunction

   task automatic run(input int idx, input vec_t v);
      vec_t             o, e;
      int               cyc = 0, wi_c = 0, wm_c = 0, viol = 0;
      bit               done = 1'b0, pend = 1'b0;
      logic             prw = 1'b0, piod = 1'b0;
      logic [CNT_W-1:0] n0;
      o = v;
      o.regw = 0; o.mdr = 0; o.pcw = 0; o.pcwc = 0; o.wwd = 0;
      o.memw = 0; o.p2r = 0; o.m2r = 0; o.src = 0;
      exp_q.push_back(v);
      opcode = v.op; func_code = v.fn; bcond = v.bc;
      n0 = num_inst;
      while (!done && cyc < 60) begin
         if (mem_req && !i_or_d) begin
            if (wi_c < v.wi) begin mem_ack = 1'b0; wi_c++; end
            else mem_ack = 1'b1;
         end else if (mem_req) begin
            if (wm_c < v.wm) begin mem_ack = 1'b0; wm_c++; end
            else mem_ack = 1'b1;
         end else begin
            mem_ack = v.noise;
         end
         #1;
         if (pend && (!mem_req || mem_rw !== prw || i_or_d !== piod)) viol++;
         pend = mem_req && !mem_ack;
         prw  = mem_rw;
         piod = i_or_d;
         o.regw += int'(reg_write);
         o.mdr  += int'(mdr_write);
         o.pcw  += int'(pc_write);
         o.pcwc += int'(pc_write_cond);
         o.wwd  += int'(wwd_valid);
         o.memw += int'(mem_req && mem_rw);
         o.p2r  += int'(pc_to_reg);
         o.m2r  += int'(mem_to_reg);
         o.src   = int'(pc_source);
         @(posedge clk); #1;
         cyc++;
         if (num_inst != n0) done = 1'b1;
      end
      mem_ack = 1'b0;
      e = exp_q.pop_front();
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout v%0d: no retire after %0d cycles, expected %0d", idx, cyc, e.cyc);
      end else begin
         mdl_cnt++;
         check($sformatf("cycles v%0d", idx),     cyc,    e.cyc);
         check($sformatf("reg_write v%0d", idx),  o.regw, e.regw);
         check($sformatf("mdr_write v%0d", idx),  o.mdr,  e.mdr);
         check($sformatf("pc_write v%0d", idx),   o.pcw,  e.pcw);
         check($sformatf("pc_wr_cond v%0d", idx), o.pcwc, e.pcwc);
         check($sformatf("wwd_valid v%0d", idx),  o.wwd,  e.wwd);
         check($sformatf("mem_write v%0d", idx),  o.memw, e.memw);
         check($sformatf("pc_to_reg v%0d", idx),  o.p2r,  e.p2r);
         check($sformatf("mem_to_reg v%0d", idx), o.m2r,  e.m2r);
         check($sformatf("pc_source v%0d", idx),  o.src,  e.src);
         check($sformatf("num_inst v%0d", idx),   int'(num_inst), mdl_cnt);
         check($sformatf("req_stable v%0d", idx), viol,   0);
      end
   endtask

   vec_t tbl[18];

   initial begin
      int bad;
      //               op fn bc wi wm nz cyc rw md pw pc ww mw p2 m2 src
      tbl[0]  = mk( 4,  5, 0, 0, 0, 1,  4, 1, 0, 1, 0, 0, 0, 0, 0, 0); // ADI 0x4105
      tbl[1]  = mk( 7,  0, 0, 3, 3, 0, 11, 1, 1, 1, 0, 0, 0, 0, 1, 0); // LWD waits
      tbl[2]  = mk( 1,  0, 1, 0, 0, 0,  3, 0, 0, 1, 1, 0, 0, 0, 0, 1); // BEQ taken
      tbl[3]  = mk( 1,  0, 0, 0, 0, 0,  3, 0, 0, 1, 1, 0, 0, 0, 0, 1); // BEQ not taken
      tbl[4]  = mk(10,  0, 0, 0, 0, 0,  2, 1, 0, 2, 0, 0, 0, 1, 0, 2); // JAL
      tbl[5]  = mk(15, 26, 0, 0, 0, 0,  2, 1, 0, 2, 0, 0, 0, 1, 0, 3); // JRL
      tbl[6]  = mk(15,  0, 0, 1, 0, 1,  5, 1, 0, 1, 0, 0, 0, 0, 0, 0); // ADD
      tbl[7]  = mk( 5,  0, 0, 0, 0, 0,  4, 1, 0, 1, 0, 0, 0, 0, 0, 0); // ORI
      tbl[8]  = mk( 6,  0, 0, 0, 0, 1,  4, 1, 0, 1, 0, 0, 0, 0, 0, 0); // LHI
      tbl[9]  = mk( 8,  0, 0, 0, 2, 0,  6, 0, 0, 1, 0, 0, 3, 0, 0, 0); // SWD
      tbl[10] = mk( 0,  0, 1, 2, 0, 0,  5, 0, 0, 1, 1, 0, 0, 0, 0, 1); // BNE
      tbl[11] = mk( 2,  0, 0, 0, 0, 1,  3, 0, 0, 1, 1, 0, 0, 0, 0, 1); // BGZ
      tbl[12] = mk( 3,  0, 1, 1, 0, 0,  4, 0, 0, 1, 1, 0, 0, 0, 0, 1); // BLZ
      tbl[13] = mk(15, 25, 0, 0, 0, 0,  2, 0, 0, 2, 0, 0, 0, 0, 0, 3); // JPR
      tbl[14] = mk( 9,  0, 0, 0, 0, 1,  2, 0, 0, 2, 0, 0, 0, 0, 0, 2); // JMP
      tbl[15] = mk(12,  0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0, 0, 0, 0); // undefined opcode
      tbl[16] = mk(15, 40, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0, 0, 0, 0); // undefined func
      tbl[17] = mk(15,  1, 0, 0, 1, 1,  4, 1, 0, 1, 0, 0, 0, 0, 0, 0); // SUB

      reset = 1'b1; opcode = '0; func_code = '0; bcond = 1'b0; mem_ack = 1'b0;
      #12;
      check("reset mem_req", int'(mem_req), 0);
      check("reset num_inst", int'(num_inst), 0);
      check("reset outs", int'({ir_write, pc_write, reg_write, is_halt, alu_src_b}), 0);
      @(negedge clk); reset = 1'b0;
      #1;
      check("IF mem_req", int'(mem_req), 1);
      check("IF alu_src_b", int'(alu_src_b), 1);
      check("IF i_or_d", int'(i_or_d), 0);

      for (int i = 0; i < 18; i++) run(i, tbl[i]);

      // SWD aborted by reset while waiting in MEM
      opcode = 4'd8; func_code = '0; mem_ack = 1'b1;
      @(posedge clk); #1; mem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort MEM req", int'({mem_req, i_or_d, mem_rw}), 7);
      @(posedge clk); #1;
      check("abort pre num_inst", int'(num_inst), mdl_cnt);
      #2 reset = 1'b1;
      #1;
      check("abort mem_req", int'(mem_req), 0);
      check("abort num_inst", int'(num_inst), 0);
      mdl_cnt = 0;
      @(negedge clk); reset = 1'b0;
      #1;
      check("abort IF", int'({mem_req, i_or_d, mem_rw}), 4);
      check("abort no count", int'(num_inst), 0);

      run(100, mk(15, 28, 0, 0, 0, 0, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0)); // WWD
      run(101, mk(15, 29, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // HLT

      bad = 0;
      for (int c = 0; c < 20; c++) begin
         mem_ack = c[0];
         #1;
         if (!is_halt || mem_req || pc_write || reg_write || ir_write || wwd_valid ||
             num_inst != CNT_W'(2)) bad++;
         @(posedge clk); #1;
      end
      check("halt hold", bad, 0);
      check("halt num_inst", int'(num_inst), 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
